i2c_target_regs: RTL and testbench
==================================

Name: i2c_target_regs

Overview:
- I2C responder (target) that exposes a small bank of 16-bit registers to an external host over the same open-drain I2C bus style the design's ADC masters use.
- Protocol is pointer-byte + 16-bit MSB-first data, the same framing the ADC initiator speaks.
- Used for host-side readback of ADC samples and sample-rate counters, and for writing reference/override values into the control path.
- Sits at top level beside the existing I2C buses; SDA is driven by an external tristate from `sda_oe_o`.

Parameters:
- ADDRESS, 7'h48, 7-bit target address.
- PTR_W, 2, pointer width; register count = 2**PTR_W.
- FILTER_LEN, 3, consecutive equal synchronized samples needed to accept an SCL/SDA level change (glitch filter).
- HOLD_CYC, 4, clk cycles after a filtered SCL falling edge before `sda_oe_o` may change.

Ports:
- clk_i  in  1  system clock (27 MHz)
- rst_ni  in  1  async active-low reset
- scl_i  in  1  I2C clock from bus (target never stretches SCL)
- sda_i  in  1  I2C data from bus
- sda_oe_o  out  1  1 = pull SDA low; 0 = release
- ptr_o  out  PTR_W  current register pointer
- rdata_i  in  16  read data for `ptr_o`; sampled as snapshot
- wdata_o  out  16  assembled write word
- wr_stb_o  out  1  one-cycle pulse; `wdata_o` valid for register `ptr_o`
- busy_o  out  1  high from addressed START (address match ACKed) until STOP

Behaviour:
- Reset: `rst_ni` is asynchronous and active-low. All flops clear:
  - `sda_oe_o`=0, `ptr_o`=0, `wdata_o`=0, `wr_stb_o`=0, `busy_o`=0, state IDLE.
  - Reset mid-transfer releases SDA immediately.
- Input conditioning: 2-FF synchronizer on `scl_i` and `sda_i`, then the FILTER_LEN glitch filter. All detection uses filtered levels.
- START: filtered SDA 1->0 while SCL=1. Valid in any state; a repeated START goes to ADDR with the bit counter cleared.
- STOP: filtered SDA 0->1 while SCL=1. Any state -> IDLE; `busy_o`=0; `sda_oe_o`=0.
- Data is sampled on the SCL rising edge. `sda_oe_o` updates HOLD_CYC cycles after the SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB-first.
    - [7:1]==ADDRESS -> ACK (drive low for the 9th clock), `busy_o`=1. R/W=0 -> PTR; R/W=1 -> load snapshot = `rdata_i`, go RD_MSB.
    - Mismatch -> no ACK, go IGNORE.
  - PTR: 8 bits.
    - bits[7:PTR_W]==0 -> ACK, `ptr_o` <= bits[PTR_W-1:0], go WR_MSB.
    - Otherwise NACK, `ptr_o` unchanged, go IGNORE.
  - WR_MSB: 8 bits, ACK, store the byte, go WR_LSB.
  - WR_LSB: 8 bits, ACK.
    - `wdata_o` <= {MSB, LSB}.
    - `wr_stb_o` pulses 1 cycle on the SCL rising edge of the 8th bit (the LSB's last data bit).
    - Further write bytes are NACKed -> IGNORE.
  - RD_MSB / RD_LSB:
    - Drive snapshot bits MSB-first: `sda_oe_o` = ~bit.
    - Release SDA for the master ACK bit and sample it on SCL rise.
    - Master ACK after LSB -> reload snapshot from `rdata_i`, go RD_MSB (repeat).
    - Master NACK -> release SDA, go IGNORE.
  - IGNORE: SDA released; wait for STOP or START.
- A pointer-only write (START, addr+W, ptr, repeated START, addr+R) sets `ptr_o`, then reads it. This is the ADC-style read.
- Snapshot: `rdata_i` is captured in the clk cycle of the ACK decision, so the host always sees a coherent 16-bit word even if `rdata_i` changes mid-byte.
- SDA released during an ACK slot counts as NACK. SDA observed low while the target releases during read data is not checked (no arbitration).

Optional Feature:
- I2C_TGT_AUTOINC_EN
- Defined:
  - `ptr_o` increments (mod 2**PTR_W) after each completed write word (same cycle as `wr_stb_o`).
  - `ptr_o` increments after each read word acknowledged by the master; the snapshot reloads from the new pointer.
  - Write bytes after LSB continue to WR_MSB instead of NACK.
- Undefined: pointer is fixed per transaction, as described above.

Test Plan:
- START, 0x90, 0x02, 0x12, 0x34, STOP -> 3 ACKs + LSB ACK; `ptr_o`=2; `wr_stb_o` one pulse with `wdata_o`=0x1234; `busy_o` low after STOP.
- START, 0x90, 0x01, rSTART, 0x91, `rdata_i`=0xABCD, read 2 bytes (ACK, NACK), STOP -> bytes 0xAB, 0xCD; `sda_oe_o`=0 after NACK.
- START, 0x92 (wrong address) -> 9th clock SDA released; no strobes; `ptr_o` unchanged; IGNORE until STOP.
- Pointer byte 0x07 with PTR_W=2 -> NACK; `ptr_o` keeps its previous value 2.
- `rdata_i` toggles 0x1111 <-> 0x2222 every 5 cycles during a read -> host reads one consistent value; 1-cycle glitches on SCL/SDA (shorter than FILTER_LEN) produce no extra bits.
- Assert `rst_ni` while the target is driving a 0 data bit -> `sda_oe_o`=0 asynchronously; after release the next START/0x90 is ACKed normally. With I2C_TGT_AUTOINC_EN: write ptr 0 then 4 data bytes -> strobes to regs 0 and 1.

Source files
------------

// File: rtl/i2c_target_regs.sv
// I2C target exposing 2**PTR_W 16-bit registers: pointer byte, then 16-bit MSB-first words.
// Optional build macro I2C_TGT_AUTOINC_EN: pointer auto-increments after each completed word.
module i2c_target_regs #(
    parameter logic [6:0]  ADDRESS    = 7'h48,
    parameter int unsigned PTR_W      = 2,
    parameter int unsigned FILTER_LEN = 3,
    parameter int unsigned HOLD_CYC   = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe_o,
    output logic [PTR_W-1:0] ptr_o,
    input  logic [15:0]      rdata_i,
    output logic [15:0]      wdata_o,
    output logic             wr_stb_o,
    output logic             busy_o
);
    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
    localparam int unsigned HCW = $clog2(HOLD_CYC + 1);

    typedef enum logic [2:0] {
        StIdle, StAddr, StPtr, StWrMsb, StWrLsb, StRdMsb, StRdLsb, StIgnore
    } state_e;

    logic [1:0]     scl_sync_q, sda_sync_q;
    logic [FCW-1:0] scl_cnt_q, sda_cnt_q;
    logic           scl_f_q, sda_f_q, scl_p_q, sda_p_q;

    // A level change is accepted only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_p_q    <= 1'b1;
            sda_p_q    <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_p_q    <= scl_f_q;
            sda_p_q    <= sda_f_q;
            if (scl_sync_q[1] == scl_f_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == FCW'(FILTER_LEN - 1)) begin
                scl_f_q   <= scl_sync_q[1];
                scl_cnt_q <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + FCW'(1);
            end
            if (sda_sync_q[1] == sda_f_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == FCW'(FILTER_LEN - 1)) begin
                sda_f_q   <= sda_sync_q[1];
                sda_cnt_q <= '0;
            end else begin
                sda_cnt_q <= sda_cnt_q + FCW'(1);
            end
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_f_q & ~scl_p_q;
    assign scl_fall  = ~scl_f_q & scl_p_q;
    assign start_det = ~sda_f_q & sda_p_q & scl_f_q;
    assign stop_det  = sda_f_q & ~sda_p_q & scl_f_q;

    state_e           state_q, state_d, pend_q, pend_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [6:0]       shreg_q, shreg_d;
    logic [7:0]       msb_q, msb_d, byte_in;
    logic [15:0]      snap_q, snap_d, wdata_q, wdata_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [HCW-1:0]   hold_q, hold_d;
    logic             ack_q, ack_d, wr_stb_q, wr_stb_d, busy_q, busy_d;
    logic             oe_q, oe_d, reload_q, reload_d, drive;

    assign byte_in = {shreg_q, sda_f_q};

    // bit_cnt: 0..7 data bits, 8 = ACK slot, 9 = ACK slot sampled, cleared on the next SCL fall.
    always_comb begin
        drive = 1'b0;
        if (bit_cnt_q == 4'd8) begin
            drive = ack_q;
        end else if (bit_cnt_q < 4'd8 && (state_q == StRdMsb || state_q == StRdLsb)) begin
            drive = ~snap_q[{state_q == StRdMsb, ~bit_cnt_q[2:0]}];
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        msb_d     = msb_q;
        snap_d    = snap_q;
        wdata_d   = wdata_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        ack_d     = ack_q;
        wr_stb_d  = 1'b0;
        busy_d    = busy_q;
        oe_d      = oe_q;
        reload_d  = 1'b0;

        if (reload_q) snap_d = rdata_i;
`ifdef I2C_TGT_AUTOINC_EN
        if (wr_stb_q) ptr_d = ptr_q + PTR_W'(1);
`endif
        if (hold_q != '0) begin
            hold_d = hold_q - HCW'(1);
            if (hold_q == HCW'(1)) oe_d = drive;
        end

        if (scl_fall) begin
            hold_d = HCW'(HOLD_CYC);
            if (bit_cnt_q == 4'd9) begin
                bit_cnt_d = 4'd0;
                ack_d     = 1'b0;
            end
        end

        if (scl_rise) begin
            if (bit_cnt_q < 4'd8) begin
                shreg_d   = byte_in[6:0];
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd7) begin
                    ack_d = 1'b0;
                    case (state_q)
                        StAddr: begin
                            if (byte_in[7:1] == ADDRESS) begin
                                ack_d  = 1'b1;
                                busy_d = 1'b1;
                                if (byte_in[0]) begin
                                    snap_d = rdata_i;
                                    pend_d = StRdMsb;
                                end else begin
                                    pend_d = StPtr;
                                end
                            end else begin
                                pend_d = StIgnore;
                            end
                        end
                        StPtr: begin
                            if ((byte_in >> PTR_W) == 8'd0) begin
                                ack_d  = 1'b1;
                                ptr_d  = byte_in[PTR_W-1:0];
                                pend_d = StWrMsb;
                            end else begin
                                pend_d = StIgnore;
                            end
                        end
                        StWrMsb: begin
                            ack_d  = 1'b1;
                            msb_d  = byte_in;
                            pend_d = StWrLsb;
                        end
                        StWrLsb: begin
                            ack_d    = 1'b1;
                            wdata_d  = {msb_q, byte_in};
                            wr_stb_d = 1'b1;
`ifdef I2C_TGT_AUTOINC_EN
                            pend_d   = StWrMsb;
`else
                            pend_d   = StIgnore;
`endif
                        end
                        default: ;
                    endcase
                end
            end else if (bit_cnt_q == 4'd8) begin
                bit_cnt_d = 4'd9;
                case (state_q)
                    StRdMsb: state_d = sda_f_q ? StIgnore : StRdLsb;
                    StRdLsb: begin
                        if (sda_f_q) begin
                            state_d = StIgnore;
                        end else begin
                            state_d = StRdMsb;
`ifdef I2C_TGT_AUTOINC_EN
                            ptr_d    = ptr_q + PTR_W'(1);
                            reload_d = 1'b1;
`else
                            snap_d   = rdata_i;
`endif
                        end
                    end
                    StAddr, StPtr, StWrMsb, StWrLsb: state_d = pend_q;
                    default: ;
                endcase
            end
        end

        if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = 4'd0;
            ack_d     = 1'b0;
        end
        if (stop_det) begin
            state_d   = StIdle;
            bit_cnt_d = 4'd0;
            ack_d     = 1'b0;
            busy_d    = 1'b0;
            oe_d      = 1'b0;
            hold_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            pend_q    <= StIdle;
            bit_cnt_q <= 4'd0;
            shreg_q   <= '0;
            msb_q     <= '0;
            snap_q    <= '0;
            wdata_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            ack_q     <= 1'b0;
            wr_stb_q  <= 1'b0;
            busy_q    <= 1'b0;
            oe_q      <= 1'b0;
            reload_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            msb_q     <= msb_d;
            snap_q    <= snap_d;
            wdata_q   <= wdata_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            ack_q     <= ack_d;
            wr_stb_q  <= wr_stb_d;
            busy_q    <= busy_d;
            oe_q      <= oe_d;
            reload_q  <= reload_d;
        end
    end

    assign sda_oe_o = oe_q;
    assign ptr_o    = ptr_q;
    assign wdata_o  = wdata_q;
    assign wr_stb_o = wr_stb_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: an open-drain bus master driving write, read and error cases.
module tb_i2c_target_regs;
    localparam int Q = 20;

    logic        clk_i  = 1'b0;
    logic        rst_ni = 1'b0;
    logic        scl_m  = 1'b1;
    logic        sda_m  = 1'b1;
    logic        sda_bus;
    logic        sda_oe_o;
    logic [1:0]  ptr_o;
    logic [15:0] rdata_i;
    logic [15:0] wdata_o;
    logic        wr_stb_o;
    logic        busy_o;

    logic [15:0] regs [4] = '{16'h0F0F, 16'hABCD, 16'h5A5A, 16'h7E81};
    logic        tog_en  = 1'b0;
    logic [15:0] tog_val = 16'h1111;

    int          checks  = 0;
    int          errors  = 0;
    int          stb_cnt = 0;
    logic [1:0]  stb_ptr [8];
    logic [15:0] stb_dat [8];

    assign sda_bus = sda_m & ~sda_oe_o;
    assign rdata_i = tog_en ? tog_val : regs[ptr_o];

    i2c_target_regs dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .scl_i    (scl_m),
        .sda_i    (sda_bus),
        .sda_oe_o (sda_oe_o),
        .ptr_o    (ptr_o),
        .rdata_i  (rdata_i),
        .wdata_o  (wdata_o),
        .wr_stb_o (wr_stb_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always begin
        repeat (5) @(negedge clk_i);
        tog_val = (tog_val == 16'h1111) ? 16'h2222 : 16'h1111;
    end

    always @(negedge clk_i) begin
        if (wr_stb_o) begin
            if (stb_cnt < 8) begin
                stb_ptr[stb_cnt] = ptr_o;
                stb_dat[stb_cnt] = wdata_o;
            end
            stb_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk_i);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    // One SCL period; optional single-cycle glitches on SCL (low phase) and SDA (high phase).
    task automatic clk_bit(input logic b, input bit glitch, output logic s);
        sda_m = b;
        repeat (Q / 2) @(negedge clk_i);
        if (glitch) begin scl_m = 1'b1; @(negedge clk_i); scl_m = 1'b0; end
        repeat (Q / 2) @(negedge clk_i);
        scl_m = 1'b1;
        repeat (Q / 2) @(negedge clk_i);
        if (glitch) begin sda_m = ~b; @(negedge clk_i); sda_m = b; end
        repeat (Q / 2) @(negedge clk_i);
        s = sda_bus;
        wait_q();
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, input bit glitch, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], glitch, s);
        clk_bit(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic read_byte(input bit mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, 1'b0, s);
            d[i] = s;
        end
        clk_bit(~mack, 1'b0, s);
    endtask

    initial begin
        logic        ack;
        logic [7:0]  rb0, rb1;
        logic [15:0] word;
        int          base;

        repeat (3) @(negedge clk_i);
        check("reset sda_oe", sda_oe_o, 1'b0);
        check("reset ptr", ptr_o, 2'd0);
        check("reset wdata", wdata_o, 16'h0);
        check("reset wr_stb", wr_stb_o, 1'b0);
        check("reset busy", busy_o, 1'b0);
        rst_ni = 1'b1;
        wait_q();

        // Single word write to register 2, with glitches on the LSB byte.
        i2c_start();
        write_byte(8'h90, 1'b0, ack); check("wr addr ack", ack, 1'b1);
        check("wr busy", busy_o, 1'b1);
        write_byte(8'h02, 1'b0, ack); check("wr ptr ack", ack, 1'b1);
        check("wr ptr value", ptr_o, 2'd2);
        write_byte(8'h12, 1'b0, ack); check("wr msb ack", ack, 1'b1);
        write_byte(8'h34, 1'b1, ack); check("wr lsb ack", ack, 1'b1);
        check("wr strobe count", stb_cnt, 1);
        check("wr strobe data", stb_dat[0], 16'h1234);
        check("wr strobe reg", stb_ptr[0], 2'd2);
        check("wr wdata", wdata_o, 16'h1234);
`ifndef I2C_TGT_AUTOINC_EN
        write_byte(8'h56, 1'b0, ack); check("wr extra nack", ack, 1'b0);
        check("wr extra no strobe", stb_cnt, 1);
`endif
        i2c_stop();
        check("wr busy after stop", busy_o, 1'b0);
        check("wr sda released", sda_oe_o, 1'b0);

        // Out-of-range pointer is refused and leaves the pointer alone.
        i2c_start();
        write_byte(8'h90, 1'b0, ack); check("badptr addr ack", ack, 1'b1);
        write_byte(8'h07, 1'b0, ack); check("badptr nack", ack, 1'b0);
`ifdef I2C_TGT_AUTOINC_EN
        check("badptr ptr kept", ptr_o, 2'd3);
`else
        check("badptr ptr kept", ptr_o, 2'd2);
`endif
        i2c_stop();

        // Pointer write, repeated START, two-byte read.
        i2c_start();
        write_byte(8'h90, 1'b0, ack); check("rd addr w ack", ack, 1'b1);
        write_byte(8'h01, 1'b0, ack); check("rd ptr ack", ack, 1'b1);
        i2c_rstart();
        write_byte(8'h91, 1'b0, ack); check("rd addr r ack", ack, 1'b1);
        read_byte(1'b1, rb0); check("rd msb", rb0, 8'hAB);
        read_byte(1'b0, rb1); check("rd lsb", rb1, 8'hCD);
        check("rd released after nack", sda_oe_o, 1'b0);
        i2c_stop();
        check("rd busy after stop", busy_o, 1'b0);
        check("rd ptr", ptr_o, 2'd1);

        // Wrong address: no ACK, ignored until STOP.
        i2c_start();
        write_byte(8'h92, 1'b0, ack); check("badaddr nack", ack, 1'b0);
        check("badaddr busy", busy_o, 1'b0);
        write_byte(8'h02, 1'b0, ack); check("badaddr ignore nack", ack, 1'b0);
        check("badaddr ptr kept", ptr_o, 2'd1);
        i2c_stop();
        check("badaddr no strobe", stb_cnt, 1);

        // Read data source toggling during the transfer.
        i2c_start();
        write_byte(8'h90, 1'b0, ack); check("tog addr ack", ack, 1'b1);
        write_byte(8'h00, 1'b0, ack); check("tog ptr ack", ack, 1'b1);
        i2c_rstart();
        tog_en = 1'b1;
        write_byte(8'h91, 1'b0, ack); check("tog addr r ack", ack, 1'b1);
        read_byte(1'b1, rb0);
        read_byte(1'b0, rb1);
        tog_en = 1'b0;
        i2c_stop();
        word = {rb0, rb1};
        check("tog coherent word", (word == 16'h1111 || word == 16'h2222), 1'b1);

        // Reset while the target pulls SDA low for a 0 data bit.
        i2c_start();
        write_byte(8'h90, 1'b0, ack);
        write_byte(8'h00, 1'b0, ack);
        i2c_rstart();
        write_byte(8'h91, 1'b0, ack); check("rst addr r ack", ack, 1'b1);
        check("rst driving bit15", sda_oe_o, 1'b1);
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1 check("rst async release", sda_oe_o, 1'b0);
        check("rst busy", busy_o, 1'b0);
        repeat (3) @(negedge clk_i);
        scl_m = 1'b1; sda_m = 1'b1;
        wait_q();
        rst_ni = 1'b1;
        wait_q();
        check("rst ptr", ptr_o, 2'd0);
        i2c_start();
        write_byte(8'h90, 1'b0, ack); check("rst addr ack after", ack, 1'b1);
        check("rst busy after", busy_o, 1'b1);
        i2c_stop();

`ifdef I2C_TGT_AUTOINC_EN
        base = stb_cnt;
        i2c_start();
        write_byte(8'h90, 1'b0, ack); check("ai addr ack", ack, 1'b1);
        write_byte(8'h00, 1'b0, ack); check("ai ptr ack", ack, 1'b1);
        write_byte(8'h11, 1'b0, ack); check("ai b0 ack", ack, 1'b1);
        write_byte(8'h22, 1'b0, ack); check("ai b1 ack", ack, 1'b1);
        write_byte(8'h33, 1'b0, ack); check("ai b2 ack", ack, 1'b1);
        write_byte(8'h44, 1'b0, ack); check("ai b3 ack", ack, 1'b1);
        i2c_stop();
        check("ai strobe count", stb_cnt - base, 2);
        check("ai strobe0 reg", stb_ptr[base], 2'd0);
        check("ai strobe0 data", stb_dat[base], 16'h1122);
        check("ai strobe1 reg", stb_ptr[base + 1], 2'd1);
        check("ai strobe1 data", stb_dat[base + 1], 16'h3344);
        check("ai ptr final", ptr_o, 2'd2);
`else
        base = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
